fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the RV32I core, directly upstream of decode and the immediate extender.
- Holds the PC and runs a single-outstanding-request handshake to instruction memory.
- Registers each fetched word and hands it to decode as instr_o, with pc_o and pcplus4_o, under valid/ready.
- Accepts a redirect (branch/jump target) from execute and discards any in-flight wrong-path fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, value of instr_o while no valid instruction is held (addi x0,x0,0).

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  synchronous, active-high reset.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address; equals the PC register.
imem_ready  in  1  memory accepts the request this cycle (req & ready = accepted).
imem_rvalid  in  1  read data valid.
imem_rdata  in  32  read data.
instr_valid  out  1  instr_o/pc_o/pcplus4_o hold a valid instruction.
instr_ready  in  1  decode consumes the instruction this cycle.
instr_o  out  32  fetched instruction word.
pc_o  out  32  address of instr_o.
pcplus4_o  out  32  pc_o + 4, modulo 2^32.
redirect  in  1  take a new PC this cycle.
redirect_pc  in  32  target PC.
misalign  out  1  one-cycle pulse: redirect_pc[1:0] != 0.

Behaviour:
- Reset values: sampled on clk when reset=1.
  - pc = RESET_PC; state = REQ; drop = 0.
  - instr_valid = 0; instr_o = NOP_INSTR; pc_o = 0; pcplus4_o = 0; misalign = 0.
- imem_req is combinational: (state==REQ) & ~redirect & ~reset. imem_addr = pc.
- FSM states and transitions:
  - REQ: on req & imem_ready, go to WAIT.
  - WAIT: wait for imem_rvalid.
    - drop=0: capture instr_o = imem_rdata, pc_o = pc, pcplus4_o = pc+4; set instr_valid; go to HOLD.
    - drop=1: discard the data, clear drop, go to REQ.
  - HOLD: instr_valid=1. On instr_ready & ~redirect: pc <= pc+4, instr_valid <= 0, instr_o <= NOP_INSTR, go to REQ.
- Latency: request accepted in cycle N, rvalid earliest in N+1, instr_valid high in N+2. Peak throughput is 1 instruction per 3 cycles.
- Redirect (highest priority after reset) in any state:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - misalign <= |redirect_pc[1:0] for one cycle; otherwise misalign <= 0.
  - REQ: no request issued that cycle; stay in REQ.
  - WAIT: set drop=1 and stay in WAIT. If rvalid arrives in the same cycle as redirect, discard it and go to REQ.
  - HOLD: instr_valid <= 0, instr_o <= NOP_INSTR, go to REQ. Redirect overrides a simultaneous instr_ready.
- Stall: in HOLD with instr_ready=0, all outputs hold stable indefinitely.
- imem_rvalid outside WAIT is ignored. This covers a stale response arriving after reset.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. Same rule for pcplus4_o.
- Reset mid-operation (any state, including WAIT with an outstanding request): immediately return to reset values. The outstanding response is ignored per the rule above.

Test Plan:
- Reset, then imem_ready=1 and rvalid one cycle after each request with rdata=32'h00500093, instr_ready=1 → imem_addr sequence 0,4,8; instr_valid pulses every 3rd cycle; pc_o=0, pcplus4_o=4 on the first instruction.
- Hold instr_ready=0 for 5 cycles after instr_valid → instr_o, pc_o, pcplus4_o stable, imem_req=0, pc unchanged until ready.
- Redirect to 32'h0000_0100 while in WAIT; old rvalid returns rdata=32'hDEADBEEF → data discarded, instr_valid stays 0, next imem_addr=32'h100.
- Redirect to 32'h0000_0042 in HOLD with instr_ready=1 in the same cycle → instr_valid drops, misalign pulses 1 cycle, next imem_addr=32'h40.
- Start from pc=32'hFFFF_FFFC (redirect there), fetch and accept → pcplus4_o=0, next imem_addr=0.
- Assert reset in WAIT, then drive rvalid in the cycle after reset releases → rvalid ignored, instr_valid=0, imem_addr=RESET_PC, imem_req=1.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// Single outstanding request: req & ready accepts, rvalid/rdata returns the word.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch stage: holds the PC, runs a single-outstanding fetch to instruction memory and
// presents each word to decode under valid/ready; a redirect discards any wrong-path fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        imem,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instr_o,
  output logic [31:0]         pc_o,
  output logic [31:0]         pcplus4_o,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  output logic                misalign
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic [31:0] pc4_q, pc4_d;
  logic        misalign_q, misalign_d;
  logic        req;

  assign req            = (state_q == StReq) & ~redirect & ~reset;
  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = valid_q;
  assign instr_o        = instr_q;
  assign pc_o           = pc_out_q;
  assign pcplus4_o      = pc4_q;
  assign misalign       = misalign_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    pc4_d      = pc4_q;
    misalign_d = 1'b0;
    if (redirect) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
      unique case (state_q)
        StWait: begin
          // A response landing with the redirect is wrong-path and is dropped right away.
          if (imem.imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = StReq;
          end else begin
            drop_d = 1'b1;
          end
        end
        StHold: begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = StReq;
        end
        default: ;
      endcase
    end else begin
      unique case (state_q)
        StReq: begin
          if (req && imem.imem_ready) state_d = StWait;
        end
        StWait: begin
          if (imem.imem_rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StReq;
            end else begin
              instr_d  = imem.imem_rdata;
              pc_out_d = pc_q;
              pc4_d    = pc_q + 32'd4;
              valid_d  = 1'b1;
              state_d  = StHold;
            end
          end
        end
        StHold: begin
          if (instr_ready) begin
            pc_d    = pc_q + 32'd4;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = StReq;
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StReq;
      pc_q       <= RESET_PC;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_out_q   <= 32'h0;
      pc4_q      <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      pc4_q      <= pc4_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
